// File: rtl/count_tick_gen.sv
// Programmable tick generator feeding the toggle-enable of a T-flip-flop up-counter.
// Optional TICKGEN_SYNC_EN adds 2-flop synchronizers on start_i/stop_i/hold_i.
module count_tick_gen #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               hold_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               tick_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] tick_cnt_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    logic start_s;
    logic stop_s;
    logic hold_s;

`ifdef TICKGEN_SYNC_EN
    logic [1:0] start_sync_q;
    logic [1:0] stop_sync_q;
    logic [1:0] hold_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_sync_q <= '0;
            stop_sync_q  <= '0;
            hold_sync_q  <= '0;
        end else begin
            start_sync_q <= {start_sync_q[0], start_i};
            stop_sync_q  <= {stop_sync_q[0], stop_i};
            hold_sync_q  <= {hold_sync_q[0], hold_i};
        end
    end

    assign start_s = start_sync_q[1];
    assign stop_s  = stop_sync_q[1];
    assign hold_s  = hold_sync_q[1];
`else
    assign start_s = start_i;
    assign stop_s  = stop_i;
    assign hold_s  = hold_i;
`endif

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIV_W-1:0]   div_eff;
    logic [BURST_W-1:0] cnt_inc;
    logic               tick_now;

    // A zero divide would never match pre_q == period-1 sensibly, so clamp to 1.
    assign div_eff  = (div_i == '0) ? DIV_W'(1) : div_i;
    assign cnt_inc  = cnt_q + BURST_W'(1);
    assign tick_now = (pre_q == (period_q - DIV_W'(1)));

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        period_d = period_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_s && !stop_s) begin
                    state_d  = S_RUN;
                    period_d = div_eff;
                    burst_d  = burst_len_i;
                    pre_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_s) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (hold_s) begin
                    busy_d = 1'b1;
                end else if (tick_now) begin
                    // busy stays up through the final-tick cycle and drops one cycle later
                    busy_d = 1'b1;
                    pre_d  = '0;
                    tick_d = 1'b1;
                    cnt_d  = cnt_inc;
                    if ((burst_q != '0) && (cnt_inc == burst_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    busy_d = 1'b1;
                    pre_d  = pre_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            period_q <= DIV_W'(1);
            burst_q  <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            period_q <= period_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tick_o     = tick_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign tick_cnt_o = cnt_q;

endmodule

// File: tb/tb_count_tick_gen.sv
// Self-checking bench for count_tick_gen: directed vector table, hand sequences,
// and randomized control checked against a behavioural reference model.
module tb_count_tick_gen;

`ifdef TICKGEN_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam int NCYC = 28;
    localparam int INF  = 1000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_r, stop_r, hold_r;
    logic [15:0] div_r;
    logic [7:0]  burst_r;
    logic        tick_o, busy_o, done_o;
    logic [7:0]  tick_cnt_o;

    always #5 clk_i = ~clk_i;

    count_tick_gen #(.DIV_W(16), .BURST_W(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_r),
        .stop_i      (stop_r),
        .hold_i      (hold_r),
        .div_i       (div_r),
        .burst_len_i (burst_r),
        .tick_o      (tick_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tick_cnt_o  (tick_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected tick pattern: 'count' ticks starting at cycle 'first', spaced 'period' apart.
    typedef struct {
        int div;
        int burst;
        int hold_lo;
        int hold_hi;
        int stop_at;
        int restart_at;
        int first;
        int period;
        int count;
        int done_cyc;
        int busy_end;
    } vec_t;

    vec_t vecs[8];

    function automatic bit exp_tick(input vec_t e, input int k);
        int j;
        if (e.count == 0) return 1'b0;
        j = k - (e.first + L);
        if (j < 0) return 1'b0;
        if ((j % e.period) != 0) return 1'b0;
        return (j / e.period) < e.count;
    endfunction

    // Reference model: cycles-remaining countdown per tick, plus input delay line.
    bit m_run;
    int m_rem, m_p, m_b, m_iss;
    bit e_tick, e_done, e_busy;
    bit d1s, d2s, d1p, d2p, d1h, d2h;

    task automatic model_reset();
        m_run = 0; m_rem = 0; m_p = 1; m_b = 0; m_iss = 0;
        e_tick = 0; e_done = 0; e_busy = 0;
        d1s = 0; d2s = 0; d1p = 0; d2p = 0; d1h = 0; d2h = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit hd, input int dv, input int bl);
        bit es, ep, eh;
        if (L == 2) begin
            es = d2s; ep = d2p; eh = d2h;
            d2s = d1s; d2p = d1p; d2h = d1h;
            d1s = st;  d1p = sp;  d1h = hd;
        end else begin
            es = st; ep = sp; eh = hd;
        end
        e_tick = 0;
        e_done = 0;
        if (!m_run) begin
            e_busy = 0;
            if (es && !ep) begin
                m_run  = 1;
                m_p    = (dv == 0) ? 1 : dv;
                m_b    = bl;
                m_rem  = m_p;
                m_iss  = 0;
                e_busy = 1;
            end
        end else if (ep) begin
            m_run  = 0;
            e_busy = 0;
        end else if (eh) begin
            e_busy = 1;
        end else begin
            e_busy = 1;
            m_rem  = m_rem - 1;
            if (m_rem == 0) begin
                e_tick = 1;
                m_iss  = (m_iss + 1) % 256;
                m_rem  = m_p;
                if (m_b != 0 && m_iss == m_b) begin
                    e_done = 1;
                    m_run  = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        start_r = 1'b0; stop_r = 1'b0; hold_r = 1'b0;
        div_r   = '0;   burst_r = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        int       ntick;
        logic [2:0] dcnt;
        bit       et, ed;

        vecs[0] = '{4, 0, -1, -1, -1, -1, 4, 4, INF, -1, 1};  // continuous
        vecs[1] = '{3, 5, -1, -1, -1, -1, 3, 3, 5, 15, 0};    // burst of 5
        vecs[2] = '{0, 3, -1, -1, -1, -1, 1, 1, 3, 3, 0};     // div 0 acts as 1
        vecs[3] = '{1, 3, -1, -1, -1, -1, 1, 1, 3, 3, 0};
        vecs[4] = '{4, 0, 2, 4, -1, -1, 7, 4, INF, -1, 1};    // hold edges 2..4
        vecs[5] = '{4, 0, -1, -1, 6, -1, 4, 4, 1, -1, 0};     // stop at edge 6
        vecs[6] = '{4, 0, -1, -1, 0, -1, 0, 1, 0, -1, 0};     // start+stop together
        vecs[7] = '{4, 0, -1, -1, -1, 6, 4, 4, INF, -1, 1};   // start in RUN ignored

        rst_ni  = 1'b0;
        start_r = 1'b0; stop_r = 1'b0; hold_r = 1'b0;
        div_r   = '0;   burst_r = '0;
        #1;
        check("reset tick_o", int'(tick_o), 0);
        check("reset busy_o", int'(busy_o), 0);
        check("reset done_o", int'(done_o), 0);
        check("reset tick_cnt_o", int'(tick_cnt_o), 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            ntick = 0;
            dcnt  = '0;
            for (int k = 0; k < NCYC; k++) begin
                start_r = (k == 0) || (k == vecs[v].restart_at);
                stop_r  = (k == vecs[v].stop_at);
                hold_r  = (k >= vecs[v].hold_lo) && (k <= vecs[v].hold_hi);
                div_r   = 16'(vecs[v].div);
                burst_r = 8'(vecs[v].burst);
                @(posedge clk_i);
                @(negedge clk_i);
                et = exp_tick(vecs[v], k);
                ed = (vecs[v].done_cyc >= 0) && (k == vecs[v].done_cyc + L);
                if (et) ntick++;
                if (tick_o) dcnt = dcnt + 3'd1;
                check($sformatf("vec%0d tick_o cyc%0d", v, k), int'(tick_o), int'(et));
                check($sformatf("vec%0d done_o cyc%0d", v, k), int'(done_o), int'(ed));
                if (ed) check($sformatf("vec%0d busy_o at done", v), int'(busy_o), 1);
            end
            start_r = 1'b0; stop_r = 1'b0; hold_r = 1'b0;
            check($sformatf("vec%0d busy_o end", v), int'(busy_o), vecs[v].busy_end);
            check($sformatf("vec%0d tick_cnt_o end", v), int'(tick_cnt_o), ntick % 256);
            check($sformatf("vec%0d downstream cnt", v), int'(dcnt), ntick % 8);
        end

        // tick_cnt_o wraps in continuous mode with P=1
        do_reset();
        ntick = 0;
        for (int k = 0; k < 260 + L; k++) begin
            start_r = (k == 0);
            div_r   = 16'd1;
            burst_r = 8'd0;
            @(posedge clk_i);
            @(negedge clk_i);
            if (tick_o) ntick++;
        end
        start_r = 1'b0;
        check("wrap tick count", ntick, 259);
        check("wrap tick_cnt_o", int'(tick_cnt_o), 259 % 256);

        // async reset while a tick is on the output
        do_reset();
        for (int k = 0; k <= 4 + L; k++) begin
            start_r = (k == 0);
            div_r   = 16'd4;
            burst_r = 8'd0;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        start_r = 1'b0;
        check("pre-reset tick_o", int'(tick_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("async reset tick_o", int'(tick_o), 0);
        check("async reset busy_o", int'(busy_o), 0);
        check("async reset done_o", int'(done_o), 0);
        check("async reset tick_cnt_o", int'(tick_cnt_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("post-reset idle tick_o %0d", k), int'(tick_o), 0);
            check($sformatf("post-reset idle busy_o %0d", k), int'(busy_o), 0);
        end

        // randomized control against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            start_r = ($urandom_range(0, 7) == 0);
            stop_r  = ($urandom_range(0, 39) == 0);
            hold_r  = ($urandom_range(0, 5) == 0);
            div_r   = 16'($urandom_range(0, 4));
            burst_r = 8'($urandom_range(0, 6));
            @(posedge clk_i);
            model_step(start_r, stop_r, hold_r, int'(div_r), int'(burst_r));
            @(negedge clk_i);
            check($sformatf("rand tick_o c%0d", c), int'(tick_o), int'(e_tick));
            check($sformatf("rand done_o c%0d", c), int'(done_o), int'(e_done));
            check($sformatf("rand busy_o c%0d", c), int'(busy_o), int'(e_busy));
            check($sformatf("rand tick_cnt_o c%0d", c), int'(tick_cnt_o), m_iss);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_tick_gen.md
Name: count_tick_gen

Overview:
- Programmable tick generator that sits directly upstream of the team's synchronous T-flip-flop up-counter.
- Produces single-cycle enable pulses (tick_o) that drive the counter's toggle-enable input, so the counter advances once every DIV_W-programmed period instead of every clock.
- Supports continuous mode and burst mode (N ticks, then stop), plus pause, stop and done/busy status.

Parameters:
- DIV_W, 16, width of the prescale divide value and internal prescale counter
- BURST_W, 8, width of the burst length and the issued-tick counter

Ports:
- clk_i  input  1  rising-edge clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  start request; acted on only in IDLE
- stop_i  input  1  abort request; priority over start_i
- hold_i  input  1  pause; freezes the prescaler while in RUN
- div_i  input  DIV_W  tick period in cycles; latched on accepted start; 0 treated as 1
- burst_len_i  input  BURST_W  ticks per burst; latched on accepted start; 0 = continuous
- tick_o  output  1  one-cycle enable pulse to the downstream counter
- busy_o  output  1  high while in RUN
- done_o  output  1  one-cycle pulse coincident with the final tick of a burst
- tick_cnt_o  output  BURST_W  ticks issued since the last accepted start

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low: clock port clk_i, reset port rst_ni.
  - All outputs are registered.
  - On rst_ni low: state=IDLE, prescale counter=0, latched period=1, latched burst=0, tick_o=0, busy_o=0, done_o=0, tick_cnt_o=0.
  - Reset asserted mid-run aborts immediately with no trailing tick.
- FSM states: IDLE, RUN.
- IDLE:
  - start_i=1 and stop_i=0 at an edge: latch P=max(div_i,1) and B=burst_len_i, clear prescale counter and tick_cnt_o, go to RUN.
  - busy_o rises after that edge.
- RUN, each edge, with conditions evaluated in this priority order:
  1. stop_i=1: go to IDLE, clear prescale counter, tick_o<=0, done_o<=0. tick_cnt_o holds its value.
  2. hold_i=1: prescale counter frozen, tick_o<=0.
  3. Prescale counter == P-1: counter<=0, tick_o<=1, tick_cnt_o<=tick_cnt_o+1.
     - In burst mode (B!=0), if tick_cnt_o+1 == B: done_o<=1 and state<=IDLE on the same edge.
  4. Otherwise: counter<=counter+1, tick_o<=0.
- start_i while in RUN is ignored; no restart.
- Latency:
  - First tick is visible in cycle P after the accepted start edge, then every P cycles, with hold cycles added.
  - P=1 gives tick_o=1 on every cycle of RUN.
- Width rules:
  - tick_cnt_o wraps modulo 2^BURST_W in continuous mode.
  - In burst mode it stops at B.
  - div_i=0 behaves exactly like div_i=1.
- done_o and the final tick are asserted in the same cycle. busy_o is 0 from the next cycle.
- Simultaneous start_i and stop_i in IDLE: remain in IDLE.
- A hold on the cycle where a tick would fire delays that tick until the first non-hold edge.

Optional Feature:
- Macro: TICKGEN_SYNC_EN.
- Defined:
  - start_i, stop_i and hold_i each pass through a 2-flop synchronizer, reset to 0 by rst_ni, before the FSM.
  - Every control response is delayed by exactly 2 cycles, including the first-tick latency (P+2 from the raw start edge).
  - Intended for asynchronous push-button control.
- Undefined: controls are sampled directly with no added latency.

Test Plan:
- Continuous mode: div_i=4, burst_len_i=0, start pulse at edge 0 -> tick_o high in cycles 4, 8, 12, 16; busy_o=1; tick_cnt_o=4 after cycle 16; done_o never asserted.
- Burst mode: div_i=3, burst_len_i=5 -> exactly 5 ticks at cycles 3, 6, 9, 12, 15; done_o=1 only in cycle 15; busy_o=0 from cycle 16; downstream 3-bit counter reads 5.
- div_i=0 and div_i=1 each with burst_len_i=3 -> ticks in cycles 1, 2, 3, done_o in cycle 3; results identical for both values.
- Hold: div_i=4, hold_i=1 for cycles 2-4 -> first tick delayed to cycle 7; subsequent ticks every 4 cycles.
- Stop and contention:
  - stop_i asserted in cycle 6 with div_i=4 -> no tick from cycle 7 on; IDLE; tick_cnt_o=1 held.
  - start_i+stop_i together in IDLE -> stays IDLE.
  - start_i pulse in RUN -> ignored.
- Reset: rst_ni low asynchronously mid-run (between edges) -> all outputs 0 immediately; after release, no ticks until a new start. With TICKGEN_SYNC_EN, repeat the continuous-mode test: first tick in cycle 6.
